// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
package voice_alloc_pkg;
  localparam int NOTE_W         = 7;
  localparam int RETRIG_GAP_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    GAP    = 2'd2,
    COMMIT = 2'd3
  } va_state_t;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [NOTE_W-1:0] vel;
  } note_ev_t;
endpackage

// File: rtl/voice_pick.sv
// Combinational note-on target search: retrigger match, then lowest free voice, then oldest.
module voice_pick
  import voice_alloc_pkg::*;
#(
  parameter  int VOICES = 4,
  parameter  int AGE_W  = 8,
  localparam int IW     = $clog2(VOICES)
) (
  input  logic [VOICES-1:0]             gate,
  input  logic [VOICES-1:0][NOTE_W-1:0] note_tbl,
  input  logic [VOICES-1:0][AGE_W-1:0]  age_tbl,
  input  logic [NOTE_W-1:0]             note,
  output logic [IW-1:0]                 idx,
  output logic                          match,
  output logic                          steal
);
  logic             free;
  logic [IW-1:0]    m_idx, f_idx, o_idx;
  logic [AGE_W-1:0] o_age;

  always_comb begin
    match = 1'b0;
    free  = 1'b0;
    m_idx = '0;
    f_idx = '0;
    // descending scan so the lowest qualifying index is the one left standing
    for (int i = VOICES-1; i >= 0; i--) begin
      if (gate[i] && note_tbl[i] == note) begin
        match = 1'b1;
        m_idx = IW'(i);
      end
      if (!gate[i]) begin
        free  = 1'b1;
        f_idx = IW'(i);
      end
    end
    o_idx = '0;
    o_age = age_tbl[0];
    for (int i = 1; i < VOICES; i++) begin
      if (age_tbl[i] > o_age) begin
        o_age = age_tbl[i];
        o_idx = IW'(i);
      end
    end
    steal = !match && !free;
    idx   = match ? m_idx : (free ? f_idx : o_idx);
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator with oldest-voice stealing and forced retrigger gap.
// Optional sustain pedal support under VOICE_ALLOCATOR_SUSTAIN_EN.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int AGE_W      = 8,
  parameter int RETRIG_GAP = RETRIG_GAP_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
  input  logic                     sustain,
`endif
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic                     ev_on,
  input  logic [NOTE_W-1:0]        ev_note,
  input  logic [NOTE_W-1:0]        ev_vel,
  output logic [VOICES-1:0]        gate,
  output logic [NOTE_W*VOICES-1:0] voice_note,
  output logic [NOTE_W*VOICES-1:0] voice_vel,
  output logic                     steal
);
  localparam int IW = $clog2(VOICES);
  localparam int GW = $clog2(RETRIG_GAP + 1);

  va_state_t                     state, state_nx;
  note_ev_t                      ev_q;
  logic [IW-1:0]                 tgt_q, pick_idx;
  logic                          pick_match, pick_steal;
  logic [GW-1:0]                 gap_cnt;
  logic [VOICES-1:0][NOTE_W-1:0] note_q, vel_q;
  logic [VOICES-1:0][AGE_W-1:0]  age_q;
  logic [VOICES-1:0]             off_hit, off_clr, rel_clr;
  logic                          accept, rel_pend_nx;

  assign accept     = ev_valid && ev_ready;
  assign voice_note = note_q;
  assign voice_vel  = vel_q;

  voice_pick #(.VOICES(VOICES), .AGE_W(AGE_W)) u_pick (
    .gate     (gate),
    .note_tbl (note_q),
    .age_tbl  (age_q),
    .note     (ev_q.note),
    .idx      (pick_idx),
    .match    (pick_match),
    .steal    (pick_steal)
  );

  always_comb begin
    for (int i = 0; i < VOICES; i++) off_hit[i] = gate[i] && (note_q[i] == ev_q.note);
  end

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
  logic              sus_q, rel_pend, rel_go;
  logic [VOICES-1:0] held;

  // release runs as a dedicated IDLE cycle with ev_ready held low
  assign rel_go      = (state == IDLE) && rel_pend && !ev_ready;
  assign rel_pend_nx = (rel_pend && !rel_go) || (sus_q && !sustain);
  assign off_clr     = sustain ? '0 : off_hit;
  assign rel_clr     = rel_go ? held : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sus_q    <= 1'b0;
      rel_pend <= 1'b0;
      held     <= '0;
    end else begin
      sus_q    <= sustain;
      rel_pend <= rel_pend_nx;
      if (state == COMMIT) begin
        if (ev_q.on)      held[tgt_q] <= 1'b0;
        else if (sustain) held        <= held | off_hit;
      end
      if (rel_go) held <= '0;
    end
  end
`else
  assign rel_pend_nx = 1'b0;
  assign off_clr     = off_hit;
  assign rel_clr     = '0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SCAN;
      // match or steal both imply the target is currently sounding
      SCAN:    state_nx = (ev_q.on && (pick_match || pick_steal)) ? GAP : COMMIT;
      GAP:     if (gap_cnt == GW'(RETRIG_GAP - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ev_ready <= 1'b0;
      steal    <= 1'b0;
      ev_q     <= '0;
      tgt_q    <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nx;
      ev_ready <= (state_nx == IDLE) && !rel_pend_nx;
      steal    <= (state == SCAN) && ev_q.on && pick_steal;
      gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (accept)         ev_q  <= '{on: ev_on, note: ev_note, vel: ev_vel};
      if (state == SCAN)  tgt_q <= pick_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate   <= '0;
      note_q <= '0;
      vel_q  <= '0;
      age_q  <= '0;
    end else begin
      case (state)
        GAP: gate[tgt_q] <= 1'b0;
        COMMIT: begin
          if (ev_q.on) begin
            for (int i = 0; i < VOICES; i++)
              if (IW'(i) != tgt_q && age_q[i] != {AGE_W{1'b1}}) age_q[i] <= age_q[i] + 1'b1;
            gate[tgt_q]   <= 1'b1;
            note_q[tgt_q] <= ev_q.note;
            vel_q[tgt_q]  <= ev_q.vel;
            age_q[tgt_q]  <= '0;
          end else begin
            gate <= gate & ~off_clr;
          end
        end
        IDLE:    gate <= gate & ~rel_clr;
        default: ;
      endcase
    end
  end
endmodule
